// File: rtl/uart_rx_byte.sv
// uart_rx_byte: UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Samples rx at mid-bit via a baud counter and strobes write_done with each good byte.
module uart_rx_byte #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] byte_out,
   output logic       write_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StParity, StStop, StDone, StWaitHigh
   } state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             idx_q;
   logic [7:0]             shreg_q;
   logic [7:0]             byte_q;
   logic                   write_done_q;
   logic                   frame_err_q;
   logic                   counting;
   logic                   data_tick;
   logic                   stop_tick;

   // Reset to 1 so a reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (!rx_s) state_d = StStart;
         StStart:    if (cnt_q == HALF) state_d = rx_s ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
         StData:     if (cnt_q == LAST && idx_q == 3'd7) state_d = StParity;
         StParity:   if (cnt_q == LAST) state_d = StStop;
`else
         StData:     if (cnt_q == LAST && idx_q == 3'd7) state_d = StStop;
`endif
         StStop:     if (cnt_q == LAST) state_d = rx_s ? StDone : StWaitHigh;
         StDone:     state_d = StIdle;
         StWaitHigh: if (rx_s) state_d = StIdle;
         default:    state_d = StIdle;
      endcase

      // Counter wraps at each bit boundary and clears on any state change.
      cnt_d = '0;
      if (counting && state_d == state_q && cnt_q != LAST) cnt_d = cnt_q + CW'(1);
   end

   always_comb begin
      busy      = (state_q != StIdle);
      counting  = (state_q == StStart) || (state_q == StData) ||
                  (state_q == StParity) || (state_q == StStop);
      data_tick = (state_q == StData) && (cnt_q == LAST);
      stop_tick = (state_q == StStop) && (cnt_q == LAST);
   end

`ifdef UART_RX_PARITY_EN
   logic parity_tick;
   logic par_bad_q;
   logic par_err_q;

   assign parity_tick = (state_q == StParity) && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         par_bad_q <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= 1'b0;
         if (parity_tick) par_bad_q <= (^shreg_q) ^ rx_s;
         if (state_q == StDone && par_bad_q) par_err_q <= 1'b1;
      end
   end
   assign parity_err = par_err_q;
`else
   logic par_bad_q;
   assign par_bad_q  = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shreg_q      <= '0;
         byte_q       <= '0;
         write_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         write_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (state_q == StStart) idx_q <= '0;
         if (data_tick) begin
            shreg_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 3'd1;
         end
         if (stop_tick && !rx_s) frame_err_q <= 1'b1;
         if (state_q == StDone && !par_bad_q) begin
            byte_q       <= shreg_q;
            write_done_q <= 1'b1;
         end
      end
   end

   assign byte_out   = byte_q;
   assign write_done = write_done_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte (CLKS_PER_BIT=16, SYNC_STAGES=2); strobes are
// matched against a scoreboard queue filled as frames are driven.
module tb_uart_rx_byte;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // Sync (2) + half start bit + remaining bits up to mid-stop + output register.
   localparam int LAT = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

   localparam int KData   = 0;
   localparam int KFrame  = 1;
   localparam int KParity = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         kind;
      logic [7:0] exp_byte;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] byte_out;
   logic       write_done;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t mon_e;
   int   mon_k;
   bit   busy_mon_en = 1'b0;
   int   busy_cnt = 0;
   vec_t vecs[6];

   uart_rx_byte #(
      .CLKS_PER_BIT(CPB),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .byte_out  (byte_out),
      .write_done(write_done),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (busy_mon_en && busy) busy_cnt++;
      if (!rst && (write_done || frame_err || parity_err)) begin
         mon_k = write_done ? KData : (frame_err ? KFrame : KParity);
         check("strobe_onehot", 32'($countones({write_done, frame_err, parity_err})), 1);
         if (sb.size() == 0) begin
            check("unexpected_strobe", mon_k, 32'hffff_ffff);
         end else begin
            mon_e = sb.pop_front();
            check("strobe_kind", mon_k, mon_e.kind);
            check("byte_out", {24'h0, byte_out}, {24'h0, mon_e.data});
            if (mon_e.cyc != 0) check("strobe_cycle", cyc, mon_e.cyc);
            if (mon_k != KFrame) check("busy_after_done", {31'h0, busy}, 0);
         end
      end
   end

   task automatic drive_bit(input logic b);
      rx_in = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Caller is aligned 1 ns after a rising edge; kind < 0 means no strobe expected.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                             input int kind, input logic [7:0] eb, input bit timed);
      exp_t e;
      e.kind = kind;
      e.data = eb;
      e.cyc  = timed ? cyc + 1 + LAT : 0;
      if (kind >= 0) sb.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ par_flip);
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      drive_bit(stop);
   endtask

   initial begin
      vecs[0] = '{data: 8'hA5, stop: 1'b1, kind: KData,  exp_byte: 8'hA5};
      vecs[1] = '{data: 8'h00, stop: 1'b1, kind: KData,  exp_byte: 8'h00};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, kind: KData,  exp_byte: 8'hFF};
      vecs[3] = '{data: 8'h3C, stop: 1'b0, kind: KFrame, exp_byte: 8'hFF};
      vecs[4] = '{data: 8'h81, stop: 1'b1, kind: KData,  exp_byte: 8'h81};
      vecs[5] = '{data: 8'h7E, stop: 1'b1, kind: KData,  exp_byte: 8'h7E};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_byte_out", {24'h0, byte_out}, 0);
      check("rst_strobes", {29'h0, write_done, frame_err, parity_err}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      rst = 1'b0;
      idle(4);

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].stop, 1'b0, vecs[i].kind, vecs[i].exp_byte,
                    vecs[i].kind == KData);
         idle(2 * CPB);
      end

      // Short glitch: rejected at the half-bit check
      busy_cnt    = 0;
      busy_mon_en = 1'b1;
      rx_in       = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(30);
      busy_mon_en = 1'b0;
      check("glitch_busy_le10", {31'h0, busy_cnt <= 10}, 1);
      check("glitch_busy_seen", {31'h0, busy_cnt > 0}, 1);
      check("glitch_byte_kept", {24'h0, byte_out}, 8'h7E);

      // Good byte, then a bad stop followed by a held-low break
      send_frame(8'hA5, 1'b1, 1'b0, KData, 8'hA5, 1'b1);
      idle(CPB);
      send_frame(8'h3C, 1'b0, 1'b0, KFrame, 8'hA5, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      check("break_busy_held", {31'h0, busy}, 1);
      check("break_byte_kept", {24'h0, byte_out}, 8'hA5);
      idle(4);
      check("break_busy_released", {31'h0, busy}, 0);
      idle(2 * CPB);

      // Back-to-back frames: timed entries enforce the 160-cycle spacing
      send_frame(8'h00, 1'b1, 1'b0, KData, 8'h00, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b0, KData, 8'hFF, 1'b1);
      idle(2 * CPB);

      // Reset during data bit 3 of 0xC3 abandons the frame
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      rx_in = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst   = 1'b1;
      rx_in = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_byte_out", {24'h0, byte_out}, 0);
      check("midrst_strobes", {29'h0, write_done, frame_err, parity_err}, 0);
      check("midrst_busy", {31'h0, busy}, 0);
      idle(20);
      send_frame(8'h81, 1'b1, 1'b0, KData, 8'h81, 1'b1);
      idle(2 * CPB);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h5A, 1'b1, 1'b0, KData, 8'h5A, 1'b1);
      idle(2 * CPB);
      send_frame(8'h5A, 1'b1, 1'b1, KParity, 8'h5A, 1'b1);
      idle(2 * CPB);
      check("parity_byte_kept", {24'h0, byte_out}, 8'h5A);
`endif

      for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
